alu_frame_interface: RTL and testbench

Parametrised framing controller between the UART RX/TX FIFOs and the ALU. It assembles multi-byte operand frames (A, B, opcode) from the RX FIFO and presents them to the ALU as stable, registered operands. After a configurable ALU latency it captures the result and streams it, LSB first, into the TX FIFO. It supersedes the single-byte interface and adds operand width scaling, inter-byte timeout recovery and an optional status byte.

---
 rtl/alu_frame_interface.sv | 215 +++++++++++++++++++++
 tb/tb_alu_frame_interface.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_interface.sv
// Frames A/B/opcode bytes from the RX FIFO into registered ALU operands and streams the result LSB first to the TX FIFO.
// Optional trailing status byte enabled by defining ALU_IF_STATUS_BYTE_EN.
module alu_frame_interface #(
  parameter int OPERAND_BYTES  = 1,
  parameter int OPCODE_WIDTH   = 4,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_rxff_empty,
  input  logic [7:0]                  i_rxff_data,
  output logic                        o_rxff_read,
  input  logic                        i_txff_full,
  output logic                        o_txff_write,
  output logic [7:0]                  o_txff_data,
  output logic [8*OPERAND_BYTES-1:0]  o_operandA,
  output logic [8*OPERAND_BYTES-1:0]  o_operandB,
  output logic [OPCODE_WIDTH-1:0]     o_opcode,
  input  logic [8*OPERAND_BYTES-1:0]  i_result,
  input  logic                        i_zero,
  input  logic                        i_carry,
  input  logic                        i_overflow,
  input  logic                        i_negative,
  input  logic                        i_exception,
  output logic                        o_busy,
  output logic                        o_frame_err,
  output logic [15:0]                 o_frames_done
);

  localparam int W  = 8 * OPERAND_BYTES;
  localparam int BW = $clog2(OPERAND_BYTES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] LAST_BYTE = BW'(OPERAND_BYTES - 1);
  localparam logic [3:0]    LAST_LAT  = 4'(ALU_LATENCY - 1);
  localparam logic [TW-1:0] LAST_IDLE = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RX_A,
    S_RX_B,
    S_RX_OP,
    S_EXEC,
    S_TX_RES
`ifdef ALU_IF_STATUS_BYTE_EN
    , S_TX_STAT
`endif
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BW-1:0]           r_bcnt;
  logic [3:0]              r_lcnt;
  logic [TW-1:0]           r_tcnt;
  logic [W-1:0]            r_asm_a;
  logic [W-1:0]            r_asm_b;
  logic [W-1:0]            r_operand_a;
  logic [W-1:0]            r_operand_b;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [W-1:0]            r_result;
  logic                    r_frame_err;
  logic [15:0]             r_frames_done;

  logic                    w_rx_state;
  logic                    w_tx_state;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_byte_last;
  logic [BW-1:0]           w_bcnt_next;
  logic                    w_idle_tick;
  logic                    w_timeout;
  logic                    w_lat_done;
  logic [7:0]              w_tx_byte;

`ifdef ALU_IF_STATUS_BYTE_EN
  logic [4:0]              r_status;
`else
  logic                    w_unused_flags;
  assign w_unused_flags = ^{i_zero, i_carry, i_overflow, i_negative, i_exception};
`endif

  assign w_rx_state  = (r_state == S_RX_A) || (r_state == S_RX_B) || (r_state == S_RX_OP);
`ifdef ALU_IF_STATUS_BYTE_EN
  assign w_tx_state  = (r_state == S_TX_RES) || (r_state == S_TX_STAT);
`else
  assign w_tx_state  = (r_state == S_TX_RES);
`endif
  // Both strobes are gated by reset so nothing moves while the block is held.
  assign w_pop       = w_rx_state && !i_rxff_empty && i_reset;
  assign w_push      = w_tx_state && !i_txff_full && i_reset;
  assign w_byte_last = (r_bcnt == LAST_BYTE);
  assign w_bcnt_next = w_byte_last ? '0 : r_bcnt + 1'b1;
  assign w_lat_done  = (r_lcnt == LAST_LAT);
  assign w_idle_tick = w_rx_state && i_rxff_empty && !((r_state == S_RX_A) && (r_bcnt == '0));
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_idle_tick && (r_tcnt == LAST_IDLE);

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset) r_state <= S_RX_A;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    w_next_state = r_state;
    w_tx_byte    = r_result[7:0];
    for (int i = 0; i < OPERAND_BYTES; i++) begin
      if (r_bcnt == BW'(i)) w_tx_byte = r_result[8*i +: 8];
    end
    case (r_state)
      S_RX_A:   if (w_pop && w_byte_last) w_next_state = S_RX_B;
      S_RX_B:   if (w_pop && w_byte_last) w_next_state = S_RX_OP;
      S_RX_OP:  if (w_pop) w_next_state = S_EXEC;
      S_EXEC:   if (w_lat_done) w_next_state = S_TX_RES;
`ifdef ALU_IF_STATUS_BYTE_EN
      S_TX_RES: if (w_push && w_byte_last) w_next_state = S_TX_STAT;
      S_TX_STAT: begin
        w_tx_byte = {3'b000, r_status};
        if (w_push) w_next_state = S_RX_A;
      end
`else
      S_TX_RES: if (w_push && w_byte_last) w_next_state = S_RX_A;
`endif
      default:  w_next_state = S_RX_A;
    endcase
    if (w_timeout) w_next_state = S_RX_A;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_bcnt        <= '0;
      r_lcnt        <= '0;
      r_tcnt        <= '0;
      r_asm_a       <= '0;
      r_asm_b       <= '0;
      r_operand_a   <= '0;
      r_operand_b   <= '0;
      r_opcode      <= '0;
      r_result      <= '0;
      r_frame_err   <= 1'b0;
      r_frames_done <= '0;
`ifdef ALU_IF_STATUS_BYTE_EN
      r_status      <= '0;
`endif
    end else begin
      r_frame_err <= w_timeout;
      r_lcnt      <= '0;
      if (w_timeout || !w_idle_tick) r_tcnt <= '0;
      else                           r_tcnt <= r_tcnt + 1'b1;

      case (r_state)
        S_RX_A: begin
          if (w_pop) begin
            for (int i = 0; i < OPERAND_BYTES; i++) begin
              if (r_bcnt == BW'(i)) r_asm_a[8*i +: 8] <= i_rxff_data;
            end
            r_bcnt <= w_bcnt_next;
          end else if (w_timeout) begin
            r_bcnt <= '0;
          end
        end
        S_RX_B: begin
          if (w_pop) begin
            for (int i = 0; i < OPERAND_BYTES; i++) begin
              if (r_bcnt == BW'(i)) r_asm_b[8*i +: 8] <= i_rxff_data;
            end
            r_bcnt <= w_bcnt_next;
          end else if (w_timeout) begin
            r_bcnt <= '0;
          end
        end
        S_RX_OP: begin
          if (w_pop) begin
            r_operand_a <= r_asm_a;
            r_operand_b <= r_asm_b;
            r_opcode    <= i_rxff_data[OPCODE_WIDTH-1:0];
          end
        end
        S_EXEC: begin
          if (w_lat_done) begin
            r_result <= i_result;
`ifdef ALU_IF_STATUS_BYTE_EN
            r_status <= {i_exception, i_negative, i_overflow, i_carry, i_zero};
`endif
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
        S_TX_RES: begin
          if (w_push) begin
            r_bcnt <= w_bcnt_next;
`ifndef ALU_IF_STATUS_BYTE_EN
            if (w_byte_last) r_frames_done <= r_frames_done + 16'd1;
`endif
          end
        end
`ifdef ALU_IF_STATUS_BYTE_EN
        S_TX_STAT: if (w_push) r_frames_done <= r_frames_done + 16'd1;
`endif
        default: ;
      endcase
    end
  end

  assign o_rxff_read   = w_pop;
  assign o_txff_write  = w_push;
  assign o_txff_data   = w_tx_byte;
  assign o_operandA    = r_operand_a;
  assign o_operandB    = r_operand_b;
  assign o_opcode      = r_opcode;
  assign o_busy        = !((r_state == S_RX_A) && (r_bcnt == '0));
  assign o_frame_err   = r_frame_err;
  assign o_frames_done = r_frames_done;

endmodule

// File: tb/tb_alu_frame_interface.sv
// Self-checking bench: FIFO models, a latency-accurate behavioural ALU and a frame-level reference model.
module tb_alu_frame_interface;

  localparam int OB  = 2;
  localparam int W   = 16;
  localparam int OW  = 4;
  localparam int LAT = 3;
  localparam int TO  = 20;
`ifdef ALU_IF_STATUS_BYTE_EN
  localparam int NB  = OB + 1;
`else
  localparam int NB  = OB;
`endif

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_rxff_empty = 1'b1;
  logic [7:0]    i_rxff_data = 8'h00;
  logic          o_rxff_read;
  logic          i_txff_full = 1'b0;
  logic          o_txff_write;
  logic [7:0]    o_txff_data;
  logic [W-1:0]  o_operandA, o_operandB;
  logic [OW-1:0] o_opcode;
  logic [W-1:0]  i_result = '0;
  logic          i_zero = 1'b0, i_carry = 1'b0, i_overflow = 1'b0, i_negative = 1'b0, i_exception = 1'b0;
  logic          o_busy, o_frame_err;
  logic [15:0]   o_frames_done;

  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  int err_pulses = 0;
  int rw_clash = 0;

  byte unsigned rxq[$];
  byte unsigned txq[$];
  bit rx_hold  = 1'b0;
  bit tx_block = 1'b0;
  bit tx_chaos = 1'b0;

  int            age = 0;
  logic [W-1:0]  last_a = '0, last_b = '0, alu_r;
  logic [OW-1:0] last_op = '0;
  logic [4:0]    alu_f;

  alu_frame_interface #(
    .OPERAND_BYTES(OB), .OPCODE_WIDTH(OW), .ALU_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rxff_empty(i_rxff_empty), .i_rxff_data(i_rxff_data), .o_rxff_read(o_rxff_read),
    .i_txff_full(i_txff_full), .o_txff_write(o_txff_write), .o_txff_data(o_txff_data),
    .o_operandA(o_operandA), .o_operandB(o_operandB), .o_opcode(o_opcode),
    .i_result(i_result), .i_zero(i_zero), .i_carry(i_carry), .i_overflow(i_overflow),
    .i_negative(i_negative), .i_exception(i_exception),
    .o_busy(o_busy), .o_frame_err(o_frame_err), .o_frames_done(o_frames_done)
  );

  always #5 i_clock = ~i_clock;

  // Reference ALU: op[1:0] selects add/sub/xor/and; opcode 0xF raises exception.
  function automatic void alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op,
                                 output logic [W-1:0] r, output logic [4:0] f);
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op[1:0])
      2'd0: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      2'd1: begin {c, r} = {1'b0, a} - {1'b0, b}; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      2'd2: r = a ^ b;
      default: r = a & b;
    endcase
    f = {op == 4'hF, r[W-1], v, c, r == '0};
  endfunction

  // Expected reply byte idx for a frame: result bytes LSB first, then the status byte.
  function automatic logic [7:0] exp_byte(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OW-1:0] op, input int idx);
    logic [W-1:0] r;
    logic [4:0]   f;
    alu_fn(a, b, op, r, f);
    if (idx < OB) return r[8*idx +: 8];
    return {3'b000, f};
  endfunction

  // FIFO models and the ALU stub; the ALU shows inverted garbage until LAT cycles after an operand change.
  always @(negedge i_clock) begin
    i_rxff_empty = rx_hold || (rxq.size() == 0);
    i_rxff_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    i_txff_full  = tx_chaos ? 1'($urandom_range(0, 1)) : tx_block;
    if (o_frame_err) err_pulses++;
    if ({o_operandA, o_operandB, o_opcode} != {last_a, last_b, last_op}) begin
      age = 1;
      last_a = o_operandA;
      last_b = o_operandB;
      last_op = o_opcode;
    end else if (age < 1000) begin
      age++;
    end
    alu_fn(o_operandA, o_operandB, o_opcode, alu_r, alu_f);
    i_result = (age >= LAT) ? alu_r : ~alu_r;
    {i_exception, i_negative, i_overflow, i_carry, i_zero} = (age >= LAT) ? alu_f : ~alu_f;
  end

  always @(posedge i_clock) begin
    if (o_rxff_read && o_txff_write) rw_clash++;
    if (o_rxff_read && rxq.size() != 0) void'(rxq.pop_front());
    if (o_txff_write) txq.push_back(o_txff_data);
  end

  task automatic wait_rx_drained();
    int n = 0;
    while (rxq.size() != 0 && n < 200) begin @(negedge i_clock); n++; end
  endtask

  // Feed one frame; first_gap starves RX after the first byte, later gaps are random up to gap_max.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] opb,
                            input int gap_max, input int first_gap);
    logic [7:0] bytes [5];
    int gap;
    bytes[0] = a[7:0]; bytes[1] = a[15:8]; bytes[2] = b[7:0]; bytes[3] = b[15:8]; bytes[4] = opb;
    for (int i = 0; i < 5; i++) begin
      rxq.push_back(bytes[i]);
      wait_rx_drained();
      gap = (i == 0) ? first_gap : $urandom_range(0, gap_max);
      if (i < 4 && gap > 0) begin
        rx_hold = 1'b1;
        repeat (gap) @(negedge i_clock);
        rx_hold = 1'b0;
      end
    end
  endtask

  task automatic collect_reply(output bit ok, output logic [8*NB-1:0] got);
    int n = 0;
    while (txq.size() < NB && n < 400) begin @(negedge i_clock); n++; end
    ok = (txq.size() >= NB);
    got = '0;
    for (int i = 0; i < NB; i++) if (txq.size() != 0) got[8*i +: 8] = txq.pop_front();
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge i_clock);
    rxq.push_back(8'h55);
    repeat (2) @(negedge i_clock);
    checks++; if (o_rxff_read !== 1'b0) begin errors++; $display("FAIL reset_rx_read got=%b want=0", o_rxff_read); end
    checks++; if (o_txff_write !== 1'b0) begin errors++; $display("FAIL reset_tx_write got=%b want=0", o_txff_write); end
    checks++; if ({o_operandA, o_operandB, o_opcode} !== '0) begin errors++; $display("FAIL reset_operands got=%h/%h/%h want=0", o_operandA, o_operandB, o_opcode); end
    checks++; if (o_frames_done !== 16'd0) begin errors++; $display("FAIL reset_frames_done got=%0d want=0", o_frames_done); end
    checks++; if ({o_busy, o_frame_err} !== 2'b00) begin errors++; $display("FAIL reset_busy_err got=%b want=00", {o_busy, o_frame_err}); end
    rxq.delete();
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
  endtask

  task automatic test_basic();
    bit ok;
    logic [8*NB-1:0] got;
    txq.delete();
    send_frame(16'h1234, 16'h0001, 8'hA0, 0, 0);
    collect_reply(ok, got);
    exp_done++;
    checks++; if (!ok) begin errors++; $display("FAIL basic_reply got=incomplete want=%0d bytes", NB); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (got[8*i +: 8] !== exp_byte(16'h1234, 16'h0001, 4'h0, i)) begin
        errors++; $display("FAIL basic_tx[%0d] got=%02h want=%02h", i, got[8*i +: 8], exp_byte(16'h1234, 16'h0001, 4'h0, i));
      end
    end
    checks++; if (o_operandA !== 16'h1234 || o_operandB !== 16'h0001 || o_opcode !== 4'h0) begin
      errors++; $display("FAIL basic_operands got=%h/%h/%h want=1234/0001/0", o_operandA, o_operandB, o_opcode); end
    checks++; if (o_frames_done !== 16'(exp_done)) begin errors++; $display("FAIL basic_frames_done got=%0d want=%0d", o_frames_done, exp_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_random();
    bit ok;
    logic [8*NB-1:0] got;
    logic [W-1:0] a, b;
    logic [7:0] opb;
    tx_chaos = 1'b1;
    for (int f = 0; f < 10; f++) begin
      txq.delete();
      a = W'($urandom); b = W'($urandom); opb = 8'($urandom);
      send_frame(a, b, opb, 5, $urandom_range(0, 5));
      collect_reply(ok, got);
      exp_done++;
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_reply got=incomplete want=%0d bytes", f, NB); end
      for (int i = 0; i < NB; i++) begin
        checks++;
        if (got[8*i +: 8] !== exp_byte(a, b, opb[OW-1:0], i)) begin
          errors++; $display("FAIL rand%0d_tx[%0d] got=%02h want=%02h", f, i, got[8*i +: 8], exp_byte(a, b, opb[OW-1:0], i));
        end
      end
      checks++; if (o_operandA !== a || o_operandB !== b || o_opcode !== opb[OW-1:0]) begin
        errors++; $display("FAIL rand%0d_operands got=%h/%h/%h want=%h/%h/%h", f, o_operandA, o_operandB, o_opcode, a, b, opb[OW-1:0]); end
      checks++; if (o_frames_done !== 16'(exp_done)) begin errors++; $display("FAIL rand%0d_frames_done got=%0d want=%0d", f, o_frames_done, exp_done); end
    end
    tx_chaos = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic test_timeout();
    bit ok;
    logic [8*NB-1:0] got;
    logic [W-1:0] keep_a, keep_b;
    int base;
    keep_a = o_operandA; keep_b = o_operandB;
    txq.delete();
    base = err_pulses;
    rxq.push_back(8'h05);
    wait_rx_drained();
    repeat (15) @(negedge i_clock);
    checks++; if (err_pulses - base !== 0) begin errors++; $display("FAIL timeout_early got=%0d pulses want=0", err_pulses - base); end
    repeat (25) @(negedge i_clock);
    checks++; if (err_pulses - base !== 1) begin errors++; $display("FAIL timeout_pulse got=%0d pulses want=1", err_pulses - base); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b want=0", o_busy); end
    checks++; if (o_operandA !== keep_a || o_operandB !== keep_b) begin
      errors++; $display("FAIL timeout_operands got=%h/%h want=%h/%h", o_operandA, o_operandB, keep_a, keep_b); end
    // A frame with a mid-frame stall shorter than the timeout must go through untouched.
    base = err_pulses;
    send_frame(16'h0001, 16'h0002, 8'h08, 0, 15);
    collect_reply(ok, got);
    exp_done++;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_reply got=incomplete want=%0d bytes", NB); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (got[8*i +: 8] !== exp_byte(16'h0001, 16'h0002, 4'h8, i)) begin
        errors++; $display("FAIL timeout_tx[%0d] got=%02h want=%02h", i, got[8*i +: 8], exp_byte(16'h0001, 16'h0002, 4'h8, i));
      end
    end
    checks++; if (err_pulses - base !== 0) begin errors++; $display("FAIL timeout_spurious got=%0d pulses want=0", err_pulses - base); end
    checks++; if (o_frames_done !== 16'(exp_done)) begin errors++; $display("FAIL timeout_frames_done got=%0d want=%0d", o_frames_done, exp_done); end
  endtask

  task automatic test_tx_stall();
    bit ok;
    logic [8*NB-1:0] got;
    txq.delete();
    tx_block = 1'b1;
    send_frame(16'hBEEF, 16'h1111, 8'h01, 0, 0);
    repeat (50) @(negedge i_clock);
    checks++; if (txq.size() !== 0) begin errors++; $display("FAIL stall_writes got=%0d want=0", txq.size()); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b want=1", o_busy); end
    tx_block = 1'b0;
    collect_reply(ok, got);
    exp_done++;
    checks++; if (!ok) begin errors++; $display("FAIL stall_reply got=incomplete want=%0d bytes", NB); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (got[8*i +: 8] !== exp_byte(16'hBEEF, 16'h1111, 4'h1, i)) begin
        errors++; $display("FAIL stall_tx[%0d] got=%02h want=%02h", i, got[8*i +: 8], exp_byte(16'hBEEF, 16'h1111, 4'h1, i));
      end
    end
    repeat (10) @(negedge i_clock);
    checks++; if (txq.size() !== 0) begin errors++; $display("FAIL stall_duplicate got=%0d extra want=0", txq.size()); end
    checks++; if (o_frames_done !== 16'(exp_done)) begin errors++; $display("FAIL stall_frames_done got=%0d want=%0d", o_frames_done, exp_done); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [8*NB-1:0] got;
    txq.delete();
    rxq.push_back(8'h99); rxq.push_back(8'h88); rxq.push_back(8'h77); rxq.push_back(8'h66);
    wait_rx_drained();
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    checks++; if ({o_operandA, o_operandB, o_opcode} !== '0) begin errors++; $display("FAIL midrst_operands got=%h/%h/%h want=0", o_operandA, o_operandB, o_opcode); end
    checks++; if (o_frames_done !== 16'd0) begin errors++; $display("FAIL midrst_frames_done got=%0d want=0", o_frames_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", o_busy); end
    i_reset = 1'b1;
    exp_done = 0;
    @(negedge i_clock);
    send_frame(16'h0007, 16'h0001, 8'h00, 0, 0);
    collect_reply(ok, got);
    exp_done++;
    checks++; if (!ok) begin errors++; $display("FAIL midrst_reply got=incomplete want=%0d bytes", NB); end
    checks++; if (got[15:0] !== 16'h0008) begin errors++; $display("FAIL midrst_result got=%04h want=0008", got[15:0]); end
    checks++; if (o_frames_done !== 16'(exp_done)) begin errors++; $display("FAIL midrst_frames_done2 got=%0d want=%0d", o_frames_done, exp_done); end
  endtask

  task automatic test_flags();
    bit ok;
    logic [8*NB-1:0] got;
    txq.delete();
    send_frame(16'hFFFF, 16'h0001, 8'h00, 0, 0);
    collect_reply(ok, got);
    exp_done++;
    checks++; if (!ok) begin errors++; $display("FAIL flags_reply got=incomplete want=%0d bytes", NB); end
    checks++; if (got[15:0] !== 16'h0000) begin errors++; $display("FAIL flags_result got=%04h want=0000", got[15:0]); end
`ifdef ALU_IF_STATUS_BYTE_EN
    checks++; if (got[23:16] !== 8'h03) begin errors++; $display("FAIL flags_status got=%02h want=03", got[23:16]); end
`endif
    repeat (5) @(negedge i_clock);
    checks++; if (txq.size() !== 0) begin errors++; $display("FAIL flags_extra_bytes got=%0d want=0", txq.size()); end
    checks++; if (o_frames_done !== 16'(exp_done)) begin errors++; $display("FAIL flags_frames_done got=%0d want=%0d", o_frames_done, exp_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_timeout();
    test_tx_stall();
    test_reset_midframe();
    test_flags();
    checks++; if (rw_clash !== 0) begin errors++; $display("FAIL rw_exclusive got=%0d overlaps want=0", rw_clash); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
